sync_asym_fifo: RTL

SYNC_ASYM_FIFO -- requirements
Module: sync_asym_fifo

---
 rtl/sync_asym_fifo.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sync_asym_fifo.sv
// sync_asym_fifo: single-clock FIFO whose write and read words may differ in
// width. Storage is kept in RAM_WIDTH-bit units, where RAM_WIDTH is the narrower
// of the two ports. The units are spread across NB interleaved banks so that the
// wide side touches one row of every bank in a single cycle. Each bank is a plain
// array with a registered read, so it can map onto block RAM.
// Optional build macro SYNC_ASYM_FIFO_PROG_FLAG_EN adds the AF_THRESH/AE_THRESH
// parameters and the almost_full/almost_empty outputs.
module sync_asym_fifo #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int WR_WIDTH       = 8,
  parameter int RD_WIDTH       = 32,
  parameter int MSB_FIRST      = 0
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
  ,
  parameter int AF_THRESH      = RAM_DEPTH - 4,
  parameter int AE_THRESH      = 4
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WR_WIDTH-1:0]       wr_data,
  output logic                      full,
  input  logic                      rd_en,
  output logic [RD_WIDTH-1:0]       rd_data,
  output logic                      rd_valid,
  output logic                      empty,
  output logic [RAM_ADDR_WIDTH:0]   unit_count,
  output logic                      overflow,
  output logic                      underflow
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
  ,
  output logic                      almost_full,
  output logic                      almost_empty
`endif
);

  localparam int RAM_WIDTH = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int WR_IND    = WR_WIDTH / RAM_WIDTH;
  localparam int RD_IND    = RD_WIDTH / RAM_WIDTH;
  // One of WR_IND/RD_IND is always 1, so the bank count is the width ratio.
  localparam int NB        = WR_IND * RD_IND;
  localparam int NB_LOG    = $clog2(NB);
  localparam int BANK_AW   = (NB > 1) ? NB_LOG : 1;
  localparam int ROWS      = RAM_DEPTH / NB;
  localparam int ROW_AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW        = RAM_ADDR_WIDTH + 1;

  localparam logic [RAM_ADDR_WIDTH-1:0] WR_STEP   = RAM_ADDR_WIDTH'(WR_IND);
  localparam logic [RAM_ADDR_WIDTH-1:0] RD_STEP   = RAM_ADDR_WIDTH'(RD_IND);
  localparam logic [RAM_ADDR_WIDTH-1:0] BANK_MASK = RAM_ADDR_WIDTH'(NB - 1);
  localparam logic [CW-1:0]             WR_INC    = CW'(WR_IND);
  localparam logic [CW-1:0]             RD_INC    = CW'(RD_IND);
  localparam logic [CW-1:0]             FULL_LIM  = CW'(RAM_DEPTH - WR_IND);
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
  localparam logic [CW-1:0]             AF_LIM    = CW'(AF_THRESH);
  localparam logic [CW-1:0]             AE_LIM    = CW'(AE_THRESH);
`endif

  logic [RAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      full_q, full_d;
  logic                      empty_q, empty_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
  logic                      almost_full_q, almost_full_d;
  logic                      almost_empty_q, almost_empty_d;
`endif

  logic                      wr_acc;
  logic                      rd_acc;
  logic [ROW_AW-1:0]         wr_row;
  logic [ROW_AW-1:0]         rd_row;
  logic [BANK_AW-1:0]        wr_bank;
  logic [BANK_AW-1:0]        rd_bank;
  logic [RAM_WIDTH-1:0]      bank_rd [NB];

  // Acceptance, pointer/count advance and next-state flags, all from pre-edge state.
  always_comb begin
    wr_acc      = wr_en && !full_q;
    rd_acc      = rd_en && !empty_q;
    wr_row      = ROW_AW'(wr_ptr_q >> NB_LOG);
    rd_row      = ROW_AW'(rd_ptr_q >> NB_LOG);
    wr_bank     = BANK_AW'(wr_ptr_q & BANK_MASK);
    rd_bank     = BANK_AW'(rd_ptr_q & BANK_MASK);
    wr_ptr_d    = wr_acc ? (wr_ptr_q + WR_STEP) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? (rd_ptr_q + RD_STEP) : rd_ptr_q;
    count_d     = count_q + (wr_acc ? WR_INC : '0) - (rd_acc ? RD_INC : '0);
    full_d      = count_d > FULL_LIM;
    empty_d     = count_d < RD_INC;
    rd_valid_d  = rd_acc;
    overflow_d  = wr_en && full_q;
    underflow_d = rd_en && empty_q;
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
    almost_full_d  = count_d >= AF_LIM;
    almost_empty_d = count_d <= AE_LIM;
`endif
  end

  // Control state registers; a reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
`endif
    end
  end

  // Unit banks. A wide access hits the same row in every bank. A narrow access
  // hits only the bank picked by the low pointer bits. The write and read
  // addresses never overlap within a cycle, because one side covers free units
  // and the other covers stored units.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      localparam int WR_SLICE = (WR_IND == 1) ? 0 :
                                ((MSB_FIRST != 0) ? (WR_IND - 1 - gi) : gi);
      logic [RAM_WIDTH-1:0] mem [ROWS];
      logic [RAM_WIDTH-1:0] rd_unit_q;
      logic                 bank_we;
      logic                 bank_re;

      assign bank_we = wr_acc && ((WR_IND > 1) || (wr_bank == BANK_AW'(gi)));
      assign bank_re = rd_acc && ((RD_IND > 1) || (rd_bank == BANK_AW'(gi)));

      // Storage write: no reset, so contents survive rst.
      always_ff @(posedge clk) begin
        if (bank_we) mem[wr_row] <= wr_data[WR_SLICE*RAM_WIDTH +: RAM_WIDTH];
      end

      // Registered read port; it holds between reads and clears on reset.
      always_ff @(posedge clk) begin
        if (rst)          rd_unit_q <= '0;
        else if (bank_re) rd_unit_q <= mem[rd_row];
      end

      assign bank_rd[gi] = rd_unit_q;
    end

    if (RD_IND > 1) begin : g_rd_wide
      for (gi = 0; gi < NB; gi++) begin : g_slice
        localparam int RD_SLICE = (MSB_FIRST != 0) ? (RD_IND - 1 - gi) : gi;
        assign rd_data[RD_SLICE*RAM_WIDTH +: RAM_WIDTH] = bank_rd[gi];
      end
    end else begin : g_rd_narrow
      logic [BANK_AW-1:0] rd_sel_q, rd_sel_d;

      assign rd_sel_d = rd_acc ? rd_bank : rd_sel_q;

      // Remember which bank the last accepted read came from.
      always_ff @(posedge clk) begin
        if (rst) rd_sel_q <= '0;
        else     rd_sel_q <= rd_sel_d;
      end

      assign rd_data = bank_rd[rd_sel_q];
    end
  endgenerate

  assign full       = full_q;
  assign empty      = empty_q;
  assign rd_valid   = rd_valid_q;
  assign unit_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
`ifdef SYNC_ASYM_FIFO_PROG_FLAG_EN
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
